// File: rtl/htif_host_pkg.sv
// Shared HTIF definitions: command byte codes, host FSM states and byte helpers.
package htif_host_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;

  // Command bytes understood by the target-side htif bridge
  localparam logic [BYTE_W-1:0] CMD_A  = 8'h61;  // 'a' set address
  localparam logic [BYTE_W-1:0] CMD_R  = 8'h72;  // 'r' 32-bit read
  localparam logic [BYTE_W-1:0] CMD_W  = 8'h77;  // 'w' 32-bit write
  localparam logic [BYTE_W-1:0] CMD_RL = 8'h52;  // 'R' 64-bit read, never issued by the host
  localparam logic [BYTE_W-1:0] CMD_WL = 8'h57;  // 'W' 64-bit write, never issued by the host

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ADDR  = 4'd1,
    ST_OP    = 4'd2,
    ST_WDATA = 4'd3,
    ST_RDATA = 4'd4,
    ST_RESP  = 4'd5
  } state_e;

  function automatic logic [BYTE_W-1:0] byte_of(input logic [DATA_W-1:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: BYTE_W];
  endfunction

  function automatic logic [BYTE_W-1:0] op_byte(input logic wr);
    return wr ? CMD_W : CMD_R;
  endfunction

endpackage

// File: rtl/htif_host_if.sv
// Command/response, tx byte and rx byte channels between a controller and htif_host.
interface htif_host_if;
  import htif_host_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_data;
  logic              addr_invalidate;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [BYTE_W-1:0] rx_data;

  // Controller plus serial link endpoints
  modport master (
    output cmd_valid, cmd_write, cmd_address, cmd_data, addr_invalidate,
    output res_ready, tx_ready, rx_valid, rx_data,
    input  cmd_ready, res_valid, res_data, tx_valid, tx_data, rx_ready
  );

  // htif_host side
  modport slave (
    input  cmd_valid, cmd_write, cmd_address, cmd_data, addr_invalidate,
    input  res_ready, tx_ready, rx_valid, rx_data,
    output cmd_ready, res_valid, res_data, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/htif_host.sv
// HTIF host initiator: serialises word read/write requests into a/r/w byte commands
// and assembles 4-byte little-endian read replies into 32-bit responses.
module htif_host
  import htif_host_pkg::*;
#(
  parameter bit ALWAYS_SEND_ADDR = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  htif_host_if.slave  bus,
  output logic [3:0]  s
);

  state_e            state, state_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic              tx_valid_q, tx_valid_n;
  logic [BYTE_W-1:0] tx_data_q, tx_data_n;
  logic              rx_ready_q, rx_ready_n;
  logic              res_valid_q, res_valid_n;
  logic [DATA_W-1:0] res_data_q, res_data_n;
  logic [ADDR_W-1:0] tgt_addr_q, tgt_addr_n;
  logic              tgt_known_q, tgt_known_n;
  logic              req_write_q, req_write_n;
  logic [DATA_W-1:0] req_data_q, req_data_n;

  logic idle_c, accept_c, tx_hs_c, rx_hs_c, res_hs_c, need_addr_c;

  assign idle_c      = (state == ST_IDLE) & ~reset;
  assign accept_c    = bus.cmd_valid & idle_c;
  assign tx_hs_c     = tx_valid_q & bus.tx_ready;
  assign rx_hs_c     = rx_ready_q & bus.rx_valid;
  assign res_hs_c    = res_valid_q & bus.res_ready;
  // An invalidate in the accept cycle forces the address out
  assign need_addr_c = ALWAYS_SEND_ADDR | ~tgt_known_q | bus.addr_invalidate
                     | (bus.cmd_address != tgt_addr_q);

  assign bus.cmd_ready = idle_c;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.rx_ready  = rx_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign s             = state;

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    idx_n       = idx_q;
    tx_valid_n  = tx_valid_q;
    tx_data_n   = tx_data_q;
    rx_ready_n  = rx_ready_q;
    res_valid_n = res_valid_q;
    res_data_n  = res_data_q;
    tgt_addr_n  = tgt_addr_q;
    tgt_known_n = tgt_known_q & ~bus.addr_invalidate;
    req_write_n = req_write_q;
    req_data_n  = req_data_q;

    unique case (state)
      ST_IDLE: begin
        if (accept_c) begin
          req_write_n = bus.cmd_write;
          req_data_n  = bus.cmd_data;
          tx_valid_n  = 1'b1;
          idx_n       = '0;
          if (need_addr_c) begin
            tx_data_n   = CMD_A;
            tgt_addr_n  = bus.cmd_address;
            tgt_known_n = 1'b1;
            state_n     = ST_ADDR;
          end else begin
            tx_data_n = op_byte(bus.cmd_write);
            state_n   = ST_OP;
          end
        end
      end
      // idx is the byte currently on tx_data: 0 = 'a', 1..4 = address bytes
      ST_ADDR: begin
        if (tx_hs_c) begin
          if (idx_q == 3'd4) begin
            tx_data_n = op_byte(req_write_q);
            state_n   = ST_OP;
          end else begin
            tx_data_n = byte_of(tgt_addr_q, idx_q[1:0]);
            idx_n     = 3'(idx_q + 3'd1);
          end
        end
      end
      ST_OP: begin
        if (tx_hs_c) begin
          tgt_addr_n = tgt_addr_q + 32'd4;
          idx_n      = '0;
          if (req_write_q) begin
            tx_data_n = byte_of(req_data_q, 2'd0);
            state_n   = ST_WDATA;
          end else begin
            tx_valid_n = 1'b0;
            rx_ready_n = 1'b1;
            state_n    = ST_RDATA;
          end
        end
      end
      ST_WDATA: begin
        if (tx_hs_c) begin
          if (idx_q == 3'd3) begin
            tx_valid_n = 1'b0;
            state_n    = ST_IDLE;
          end else begin
            tx_data_n = byte_of(req_data_q, 2'(idx_q + 3'd1));
            idx_n     = 3'(idx_q + 3'd1);
          end
        end
      end
      // Shift in from the top so the first byte ends up in [7:0]
      ST_RDATA: begin
        if (rx_hs_c) begin
          res_data_n = {bus.rx_data, res_data_q[DATA_W-1:BYTE_W]};
          idx_n      = 3'(idx_q + 3'd1);
          if (idx_q == 3'd3) begin
            rx_ready_n  = 1'b0;
            res_valid_n = 1'b1;
            state_n     = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (res_hs_c) begin
          res_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      tgt_addr_q  <= '0;
      tgt_known_q <= 1'b0;
      req_write_q <= 1'b0;
      req_data_q  <= '0;
    end else begin
      state       <= state_n;
      idx_q       <= idx_n;
      tx_valid_q  <= tx_valid_n;
      tx_data_q   <= tx_data_n;
      rx_ready_q  <= rx_ready_n;
      res_valid_q <= res_valid_n;
      res_data_q  <= res_data_n;
      tgt_addr_q  <= tgt_addr_n;
      tgt_known_q <= tgt_known_n;
      req_write_q <= req_write_n;
      req_data_q  <= req_data_n;
    end
  end

endmodule

// File: tb/tb_htif_host.sv
// Directed bench for htif_host: byte scoreboard on tx, scripted rx replies.
module tb_htif_host;
  import htif_host_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s;
  int         checks = 0;
  int         errors = 0;
  bq_t        txq;
  bq_t        rxq;
  int         rx_count = 0;
  int         txv_cycles = 0;
  bit         toggle = 1'b0;

  htif_host_if bus ();

  htif_host #(.ALWAYS_SEND_ADDR(1'b0)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus),
    .s     (s)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // tx scoreboard: record every byte handed off at the following posedge
  always @(negedge clk) begin
    if (bus.tx_valid) txv_cycles++;
    if (bus.tx_valid && bus.tx_ready && !reset) txq.push_back(bus.tx_data);
  end

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = toggle ? ~bus.tx_ready : 1'b1;
    end
  end

  // rx source: offers queued bytes continuously, pops on handshake
  initial begin
    bit hs;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      bus.rx_valid = (rxq.size() != 0);
      bus.rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
      hs = bus.rx_valid && bus.rx_ready && !reset;
      @(posedge clk);
      if (hs) begin
        void'(rxq.pop_front());
        rx_count++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit inv);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid       = 1'b1;
    bus.cmd_write       = wr;
    bus.cmd_address     = a;
    bus.cmd_data        = d;
    bus.addr_invalidate = inv;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid       = 1'b0;
    bus.addr_invalidate = 1'b0;
    @(negedge clk);
    chk("first_byte_latency", 32'(bus.tx_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(s == 4'd0 && !bus.tx_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_res();
    int n = 0;
    while (!bus.res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("res_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic release_res();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("res_valid_dropped", 32'(bus.res_valid), 32'd0);
    chk("ready_after_resp", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic check_tx(input string tag, input bq_t exp);
    chk({tag, "_len"}, 32'(txq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    txq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    chk({tag, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
    chk({tag, "_rx_ready"},  32'(bus.rx_ready),  32'd0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_state"},     32'(s),             32'd0);
  endtask

  initial begin
    bq_t exp;
    int  n;
    reset               = 1'b1;
    bus.cmd_valid       = 1'b0;
    bus.cmd_write       = 1'b0;
    bus.cmd_address     = '0;
    bus.cmd_data        = '0;
    bus.addr_invalidate = 1'b0;
    bus.res_ready       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    // Write with address, back-to-back bytes
    txq.delete();
    txv_cycles = 0;
    issue(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    wait_idle();
    exp = '{8'h61, 8'h00, 8'h10, 8'h00, 8'h00, 8'h77, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_tx("wr_addr", exp);
    chk("wr_addr_cycles", 32'(txv_cycles), 32'd10);
    chk("wr_no_res", 32'(bus.res_valid), 32'd0);

    // Sequential write elides the address; rx bytes offered meanwhile must be ignored
    rxq = '{8'h11, 8'h22, 8'h33, 8'h44};
    rx_count = 0;
    issue(1'b1, 32'h0000_1004, 32'h0102_0304, 1'b0);
    wait_idle();
    exp = '{8'h77, 8'h04, 8'h03, 8'h02, 8'h01};
    check_tx("wr_elided", exp);
    chk("rx_ignored", 32'(rxq.size()), 32'd4);

    // Read with elided address, response held until consumed
    issue(1'b0, 32'h0000_1008, 32'h0, 1'b0);
    wait_res();
    exp = '{8'h72};
    check_tx("rd_elided", exp);
    chk("rd_data", bus.res_data, 32'h4433_2211);
    chk("rd_rx_count", 32'(rx_count), 32'd4);
    chk("rd_rx_ready_off", 32'(bus.rx_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("rd_hold_valid", 32'(bus.res_valid), 32'd1);
    chk("rd_hold_data", bus.res_data, 32'h4433_2211);
    chk("rd_busy", 32'(bus.cmd_ready), 32'd0);
    release_res();

    // Invalidate coinciding with accept forces the address out
    rxq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    issue(1'b0, 32'h0000_2000, 32'h0, 1'b1);
    wait_res();
    exp = '{8'h61, 8'h00, 8'h20, 8'h00, 8'h00, 8'h72};
    check_tx("rd_inval", exp);
    chk("rd_inval_data", bus.res_data, 32'hD4C3_B2A1);
    release_res();

    // Address wrap, first with tx_ready high, then toggling
    for (int pass = 0; pass < 2; pass++) begin
      toggle = (pass == 1);
      issue(1'b1, 32'hFFFF_FFFC, 32'h1111_1111, 1'b0);
      wait_idle();
      exp = '{8'h61, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h77, 8'h11, 8'h11, 8'h11, 8'h11};
      check_tx($sformatf("wrap_hi_p%0d", pass), exp);
      issue(1'b1, 32'h0000_0000, 32'h2222_2222, 1'b0);
      wait_idle();
      exp = '{8'h77, 8'h22, 8'h22, 8'h22, 8'h22};
      check_tx($sformatf("wrap_lo_p%0d", pass), exp);
    end
    toggle = 1'b0;

    // Reset after the second rx byte of a read
    rxq = '{8'h55, 8'h66, 8'h77, 8'h88};
    rx_count = 0;
    issue(1'b0, 32'h0000_0004, 32'h0, 1'b0);
    n = 0;
    while (rx_count < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rx2_timeout", 32'(n < 100), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    rxq.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    exp = '{8'h72};
    check_tx("rd_aborted", exp);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", 32'(bus.cmd_ready), 32'd1);

    // Target pointer is unknown again, so the address is re-sent
    rxq = '{8'h01, 8'h02, 8'h03, 8'h04};
    issue(1'b0, 32'h0000_0004, 32'h0, 1'b0);
    wait_res();
    exp = '{8'h61, 8'h04, 8'h00, 8'h00, 8'h00, 8'h72};
    check_tx("rd_after_reset", exp);
    chk("rd_after_reset_data", bus.res_data, 32'h0403_0201);
    release_res();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
